fpdiv_ctrl: RTL

FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

---
 rtl/fpdiv_pkg.sv | 33 +++
 rtl/fpdiv_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and encodings for the Goldschmidt divider controller.
// Select encodings must match the fpdiv datapath operand muxes.
package fpdiv_pkg;

    localparam int MANT_W = 28;
    localparam int EXP_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        LOAD_AC,
        ITER_B,
        ITER_AC,
        FINAL_B,
        ROUND,
        DONE
    } state_t;

    localparam logic [1:0] MUXA_ITER = 2'b00;
    localparam logic [1:0] MUXA_RND  = 2'b01;
    localparam logic [1:0] MUXA_INIT = 2'b10;

    localparam logic [1:0] MUXB_AC   = 2'b00;
    localparam logic [1:0] MUXB_INIT = 2'b01;
    localparam logic [1:0] MUXB_ITER = 2'b10;
    localparam logic [1:0] MUXB_SQ   = 2'b11;

    // Hidden leading one, 23-bit fraction, four guard bits for the datapath.
    function automatic logic [MANT_W-1:0] mant_of(input logic [31:0] bits);
        return {1'b1, bits[22:0], 4'b0000};
    endfunction

endpackage

// File: rtl/fpdiv_ctrl.sv
// Sequencer for the fpdiv Goldschmidt datapath: captures the operands on an
// accepted start, then steps the mux selects and register enables through the iterations.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int NITER = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       x_bits,
    input  logic [31:0]       d_bits,
    input  logic              rm_in,
    output logic [MANT_W-1:0] x,
    output logic [MANT_W-1:0] d,
    output logic [EXP_W-1:0]  x_exp,
    output logic [EXP_W-1:0]  d_exp,
    output logic              x_sign,
    output logic              d_sign,
    output logic [1:0]        sel_muxa,
    output logic [1:0]        sel_muxb,
    output logic              enA,
    output logic              enB,
    output logic              enC,
    output logic              enR,
    output logic              rMode,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(NITER) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NITER - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    assign accept = (state_q == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands are frozen for the whole operation; only an accepted start reloads them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x      <= '0;
            d      <= '0;
            x_exp  <= '0;
            d_exp  <= '0;
            x_sign <= 1'b0;
            d_sign <= 1'b0;
            rMode  <= 1'b0;
        end else if (accept) begin
            x      <= mant_of(x_bits);
            d      <= mant_of(d_bits);
            x_exp  <= x_bits[30:23];
            d_exp  <= d_bits[30:23];
            x_sign <= x_bits[31];
            d_sign <= d_bits[31];
            rMode  <= rm_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_muxa = MUXA_ITER;
        sel_muxb = MUXB_AC;
        enA      = 1'b0;
        enB      = 1'b0;
        enC      = 1'b0;
        enR      = 1'b0;
        done     = 1'b0;
        busy     = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_B;
            end
            LOAD_B: begin
                sel_muxa = MUXA_INIT;
                sel_muxb = MUXB_INIT;
                enB      = 1'b1;
                state_d  = LOAD_AC;
            end
            LOAD_AC: begin
                sel_muxa = MUXA_INIT;
                sel_muxb = MUXB_AC;
                enA      = 1'b1;
                enC      = 1'b1;
                cnt_d    = '0;
                state_d  = ITER_B;
            end
            ITER_B: begin
                sel_muxb = MUXB_ITER;
                enB      = 1'b1;
                state_d  = ITER_AC;
            end
            ITER_AC: begin
                sel_muxb = MUXB_SQ;
                enA      = 1'b1;
                enC      = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = (cnt_q < LAST_ITER) ? ITER_B : FINAL_B;
            end
            FINAL_B: begin
                sel_muxb = MUXB_ITER;
                enB      = 1'b1;
                state_d  = ROUND;
            end
            ROUND: begin
                sel_muxa = MUXA_RND;
                sel_muxb = MUXB_ITER;
                enR      = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                sel_muxa = MUXA_RND;
                sel_muxb = MUXB_ITER;
                done     = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
